// File: rtl/mul_sched.sv
// mul_sched: shares NUM_MUL multiplier units between operand flits from one
// router port. Pairs A/B operands, dispatches each pair round-robin to a free
// unit (A flit then B flit), and returns result flits with a rewritten header
// on a send/ack output port with round-robin arbitration.
// Optional watchdog: define MUL_SCHED_TIMEOUT_EN to force-free units that
// never answer within TIMEOUT cycles.
module mul_sched #(
    parameter int unsigned NUM_MUL   = 2,
    parameter logic [3:0]  DEST_ADDR = 4'b1000,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [70:0]            in_flit,
    output logic                   in_ready,
    output logic [71*NUM_MUL-1:0]  mul_in_flit,
    input  logic [71*NUM_MUL-1:0]  mul_result_flit,
    input  logic [NUM_MUL-1:0]     mul_ready_send,
    output logic [70:0]            out_flit,
    output logic                   out_send,
    input  logic                   out_ack,
    output logic [NUM_MUL-1:0]     unit_busy,
    output logic                   timeout_err
);

    localparam int unsigned FLIT_W = 71;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned IDX_W  = (NUM_MUL > 1) ? $clog2(NUM_MUL) : 1;

    typedef enum logic [1:0] {
        COLLECT,
        WAIT_UNIT,
        SEND_A,
        SEND_B
    } state_t;

    state_t                 state;
    logic [DATA_W-1:0]      reg_a;
    logic [DATA_W-1:0]      reg_b;
    logic                   has_a;
    logic                   has_b;
    logic [IDX_W-1:0]       disp_ptr;
    logic [IDX_W-1:0]       sel;
    logic [IDX_W-1:0]       out_ptr;
    logic [IDX_W-1:0]       out_idx;
    logic [NUM_MUL-1:0]     pending;
    logic [DATA_W-1:0]      res [NUM_MUL];

    logic                   in_valid;
    logic                   acc_a;
    logic                   acc_b;
    logic                   has_a_nx;
    logic                   has_b_nx;
    logic [NUM_MUL-1:0]     eligible;
    logic [NUM_MUL-1:0]     cap;
    logic [NUM_MUL-1:0]     disp_set;
    logic [NUM_MUL-1:0]     ack_clr;
    logic [NUM_MUL-1:0]     to_hit;
    logic                   disp_found;
    logic [IDX_W-1:0]       disp_idx;
    logic                   out_found;
    logic [IDX_W-1:0]       out_pick;
    int unsigned            cand_d;
    int unsigned            cand_o;
    logic                   unused_hdr;

    // Increment a unit index, wrapping at NUM_MUL.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (32'(i) == NUM_MUL - 1) ? '0 : i + 1'b1;
    endfunction

    assign in_valid = (in_flit[70:69] == 2'b11);
    assign acc_a    = in_valid && in_ready && !in_flit[64];
    assign acc_b    = in_valid && in_ready && in_flit[64];
    assign has_a_nx = has_a || acc_a;
    assign has_b_nx = has_b || acc_b;

    assign eligible = ~unit_busy & ~pending;
    assign cap      = mul_ready_send & unit_busy;
    assign disp_set = (state == SEND_B) ? (NUM_MUL'(1) << sel) : '0;
    assign ack_clr  = (out_send && out_ack) ? (NUM_MUL'(1) << out_idx) : '0;

    // First eligible unit at or after the dispatch pointer.
    always_comb begin
        disp_found = 1'b0;
        disp_idx   = '0;
        cand_d     = 0;
        for (int unsigned off = 0; off < NUM_MUL; off++) begin
            cand_d = (32'(disp_ptr) + off) % NUM_MUL;
            if (!disp_found && eligible[IDX_W'(cand_d)]) begin
                disp_found = 1'b1;
                disp_idx   = IDX_W'(cand_d);
            end
        end
    end

    // First pending result at or after the output pointer.
    always_comb begin
        out_found = 1'b0;
        out_pick  = '0;
        cand_o    = 0;
        for (int unsigned off = 0; off < NUM_MUL; off++) begin
            cand_o = (32'(out_ptr) + off) % NUM_MUL;
            if (!out_found && pending[IDX_W'(cand_o)]) begin
                out_found = 1'b1;
                out_pick  = IDX_W'(cand_o);
            end
        end
    end

    // Header bits of results and the incoming dest field carry no information here.
    always_comb begin
        unused_hdr = ^in_flit[68:65];
        for (int i = 0; i < int'(NUM_MUL); i++) begin
            unused_hdr = unused_hdr ^ (^mul_result_flit[FLIT_W*i+DATA_W +: FLIT_W-DATA_W]);
        end
    end

    // Pairing and dispatch FSM; unit slices are zero except for the two send cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= COLLECT;
            in_ready    <= 1'b0;
            reg_a       <= '0;
            reg_b       <= '0;
            has_a       <= 1'b0;
            has_b       <= 1'b0;
            disp_ptr    <= '0;
            sel         <= '0;
            mul_in_flit <= '0;
        end else begin
            mul_in_flit <= '0;
            in_ready    <= 1'b0;
            case (state)
                COLLECT: begin
                    has_a <= has_a_nx;
                    has_b <= has_b_nx;
                    if (acc_a) reg_a <= in_flit[63:0];
                    if (acc_b) reg_b <= in_flit[63:0];
                    if (has_a && has_b) begin
                        state <= WAIT_UNIT;
                    end else begin
                        // Stop accepting as soon as the pair completes.
                        in_ready <= !(has_a_nx && has_b_nx);
                    end
                end
                WAIT_UNIT: begin
                    if (disp_found) begin
                        sel   <= disp_idx;
                        state <= SEND_A;
                        mul_in_flit[FLIT_W*disp_idx +: FLIT_W] <= {2'b11, 4'b0000, 1'b0, reg_a};
                    end
                end
                SEND_A: begin
                    mul_in_flit[FLIT_W*sel +: FLIT_W] <= {2'b11, 4'b0000, 1'b1, reg_b};
                    state <= SEND_B;
                end
                SEND_B: begin
                    has_a    <= 1'b0;
                    has_b    <= 1'b0;
                    disp_ptr <= next_idx(sel);
                    in_ready <= 1'b1;
                    state    <= COLLECT;
                end
                default: state <= COLLECT;
            endcase
        end
    end

    // Unit occupancy, result capture and round-robin output with send/ack.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            unit_busy <= '0;
            pending   <= '0;
            out_send  <= 1'b0;
            out_flit  <= '0;
            out_ptr   <= '0;
            out_idx   <= '0;
            for (int i = 0; i < int'(NUM_MUL); i++) res[i] <= '0;
        end else begin
            unit_busy <= (unit_busy & ~cap & ~to_hit) | disp_set;
            pending   <= (pending | cap) & ~ack_clr;
            for (int i = 0; i < int'(NUM_MUL); i++) begin
                if (cap[i]) res[i] <= mul_result_flit[FLIT_W*i +: DATA_W];
            end
            if (out_send) begin
                if (out_ack) begin
                    out_send <= 1'b0;
                    out_ptr  <= next_idx(out_idx);
                end
            end else if (out_found) begin
                out_send <= 1'b1;
                out_idx  <= out_pick;
                out_flit <= {2'b11, DEST_ADDR, 1'b0, res[out_pick]};
            end
        end
    end

`ifdef MUL_SCHED_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt [NUM_MUL];

    // A unit times out on its TIMEOUT-th busy cycle unless its strobe arrives then.
    always_comb begin
        to_hit = '0;
        for (int i = 0; i < int'(NUM_MUL); i++) begin
            to_hit[i] = unit_busy[i] && !mul_ready_send[i] && (cnt[i] == CNT_W'(TIMEOUT - 1));
        end
    end

    // Per-unit busy-cycle counters and the error pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timeout_err <= 1'b0;
            for (int i = 0; i < int'(NUM_MUL); i++) cnt[i] <= '0;
        end else begin
            timeout_err <= |to_hit;
            for (int i = 0; i < int'(NUM_MUL); i++) begin
                if (disp_set[i]) cnt[i] <= '0;
                else if (unit_busy[i]) cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end
`else
    logic unused_timeout;

    assign to_hit         = '0;
    assign timeout_err    = 1'b0;
    assign unused_timeout = (TIMEOUT != 0);
`endif

endmodule

// File: tb/tb_mul_sched.sv
// Testbench for mul_sched (NUM_MUL=2). Table of single-pair vectors plus
// hand-written sequences for multi-unit arbitration, back-pressure,
// mid-dispatch reset and the watchdog (MUL_SCHED_TIMEOUT_EN).
module tb_mul_sched;

    localparam int NM = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [70:0]    in_flit;
    logic           in_ready;
    logic [141:0]   mul_in_flit;
    logic [141:0]   mul_result_flit;
    logic [NM-1:0]  mul_ready_send;
    logic [70:0]    out_flit;
    logic           out_send;
    logic           out_ack;
    logic [NM-1:0]  unit_busy;
    logic           timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          n;
        logic        t0, t1, t2;
        logic [63:0] d0, d1, d2;
        logic [63:0] exp_a, exp_b;
        int          exp_unit;
        logic [63:0] exp_res;
    } vec_t;

    vec_t vecs[5];

    mul_sched #(.NUM_MUL(2), .DEST_ADDR(4'b1000), .TIMEOUT(64)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_flit         (in_flit),
        .in_ready        (in_ready),
        .mul_in_flit     (mul_in_flit),
        .mul_result_flit (mul_result_flit),
        .mul_ready_send  (mul_ready_send),
        .out_flit        (out_flit),
        .out_send        (out_send),
        .out_ack         (out_ack),
        .unit_busy       (unit_busy),
        .timeout_err     (timeout_err)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input int n, input logic t0, input logic [63:0] d0,
                                input logic t1, input logic [63:0] d1,
                                input logic t2, input logic [63:0] d2,
                                input logic [63:0] ea, input logic [63:0] eb,
                                input int eu, input logic [63:0] er);
        vec_t v;
        v.n = n; v.t0 = t0; v.d0 = d0; v.t1 = t1; v.d1 = d1; v.t2 = t2; v.d2 = d2;
        v.exp_a = ea; v.exp_b = eb; v.exp_unit = eu; v.exp_res = er;
        return v;
    endfunction

    function automatic logic [70:0] opf(input logic tag, input logic [63:0] d);
        return {2'b11, 4'b0000, tag, d};
    endfunction

    function automatic logic [70:0] resf(input logic [63:0] d);
        return {2'b11, 4'b1000, 1'b0, d};
    endfunction

    task automatic chk(input string nm, input logic [143:0] act, input logic [143:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst in_ready", in_ready, 0);
        chk("rst out_send", out_send, 0);
        chk("rst out_flit", out_flit, 0);
        chk("rst slices", mul_in_flit, 0);
        chk("rst unit_busy", unit_busy, 0);
        chk("rst timeout_err", timeout_err, 0);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic send_flit(input logic tag, input logic [63:0] d);
        int w = 0;
        while (!in_ready && w < 50) begin
            tick();
            w++;
        end
        chk("in_ready wait", in_ready, 1);
        in_flit = opf(tag, d);
        tick();
        in_flit = '0;
    endtask

    task automatic check_dispatch(input string nm, input int u, input logic [63:0] a, input logic [63:0] b);
        int lat = 0;
        logic [141:0] ev;
        while (mul_in_flit == '0 && lat < 50) begin
            tick();
            lat++;
        end
        chk({nm, " latency"}, lat, 2);
        ev = '0;
        ev[71*u +: 71] = opf(1'b0, a);
        chk({nm, " slice A"}, mul_in_flit, ev);
        tick();
        ev = '0;
        ev[71*u +: 71] = opf(1'b1, b);
        chk({nm, " slice B"}, mul_in_flit, ev);
        tick();
        chk({nm, " slices clear"}, mul_in_flit, 0);
        chk({nm, " busy bit"}, unit_busy[u], 1);
    endtask

    task automatic strobe(input logic [NM-1:0] mask, input logic [63:0] d0, input logic [63:0] d1);
        mul_result_flit = {opf(1'b0, d1), opf(1'b0, d0)};
        mul_ready_send  = mask;
        tick();
        mul_ready_send  = '0;
        mul_result_flit = '0;
    endtask

    task automatic wait_out(input string nm);
        int w = 0;
        while (!out_send && w < 50) begin
            tick();
            w++;
        end
        chk({nm, " out_send"}, out_send, 1);
    endtask

    task automatic expect_out(input string nm, input logic [63:0] d);
        wait_out(nm);
        chk({nm, " out_flit"}, out_flit, resf(d));
        repeat (3) tick();
        chk({nm, " held"}, {out_send, out_flit}, {1'b1, resf(d)});
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;
        chk({nm, " after ack"}, {out_send, out_flit}, {1'b0, resf(d)});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [143:0] acc;
        int busy_n, pulses, sends;
        rst_n = 1'b0;
        in_flit = '0;
        mul_result_flit = '0;
        mul_ready_send = '0;
        out_ack = 1'b0;

        vecs[0] = mk(2, 1'b0, 64'd5, 1'b1, 64'd7, 1'b0, 64'd0, 64'd5, 64'd7, 0, 64'd35);
        vecs[1] = mk(2, 1'b1, 64'd9, 1'b0, 64'd2, 1'b0, 64'd0, 64'd2, 64'd9, 1, 64'd18);
        vecs[2] = mk(3, 1'b0, 64'd1, 1'b0, 64'd8, 1'b1, 64'd3, 64'd8, 64'd3, 0, 64'd24);
        vecs[3] = mk(2, 1'b0, 64'hDEAD_BEEF_0000_0001, 1'b1, 64'd2, 1'b0, 64'd0,
                     64'hDEAD_BEEF_0000_0001, 64'd2, 1, 64'hBD5B_7DDE_0000_0002);
        vecs[4] = mk(3, 1'b1, 64'd4, 1'b1, 64'd11, 1'b0, 64'd3, 64'd3, 64'd11, 0, 64'd33);

        do_reset();

        // Single pairs: pairing order, overwrite, round-robin units, passthrough.
        for (int k = 0; k < 5; k++) begin
            send_flit(vecs[k].t0, vecs[k].d0);
            send_flit(vecs[k].t1, vecs[k].d1);
            if (vecs[k].n == 3) send_flit(vecs[k].t2, vecs[k].d2);
            check_dispatch($sformatf("v%0d", k), vecs[k].exp_unit, vecs[k].exp_a, vecs[k].exp_b);
            repeat (3) tick();
            strobe((vecs[k].exp_unit == 0) ? 2'b01 : 2'b10,
                   vecs[k].exp_a * vecs[k].exp_b, vecs[k].exp_a * vecs[k].exp_b);
            expect_out($sformatf("v%0d", k), vecs[k].exp_res);
            chk($sformatf("v%0d busy idle", k), unit_busy, 0);
        end

        // Two units busy, third pair blocked, simultaneous results returned in order.
        do_reset();
        send_flit(1'b0, 64'd3);
        send_flit(1'b1, 64'd4);
        check_dispatch("p1", 0, 64'd3, 64'd4);
        send_flit(1'b0, 64'd5);
        send_flit(1'b1, 64'd3);
        check_dispatch("p2", 1, 64'd5, 64'd3);
        chk("both busy", unit_busy, 2'b11);
        send_flit(1'b0, 64'd7);
        send_flit(1'b1, 64'd7);
        acc = '0;
        for (int c = 0; c < 6; c++) begin
            acc = acc | 144'(mul_in_flit);
            tick();
        end
        chk("p3 blocked slices", acc, 0);
        chk("p3 blocked in_ready", in_ready, 0);
        repeat (4) tick();
        strobe(2'b11, 64'd12, 64'd15);
        wait_out("rr first");
        chk("rr first flit", out_flit, resf(64'd12));
        chk("p3 waits pending", mul_in_flit, 0);
        chk("captured busy", unit_busy, 2'b00);
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;
        chk("idle gap", out_send, 0);
        chk("idle gap slices", mul_in_flit, 0);
        tick();
        chk("rr second", {out_send, out_flit}, {1'b1, resf(64'd15)});
        chk("p3 slice A", mul_in_flit, {71'd0, opf(1'b0, 64'd7)});
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;
        chk("rr second acked", out_send, 0);
        chk("p3 slice B", mul_in_flit, {71'd0, opf(1'b1, 64'd7)});
        tick();
        chk("p3 slices clear", mul_in_flit, 0);
        chk("p3 busy", unit_busy, 2'b01);

        // Strobe from an idle unit is ignored.
        strobe(2'b10, 64'h99, 64'h99);
        repeat (4) tick();
        chk("idle strobe ignored", out_send, 0);
        strobe(2'b01, 64'd49, 64'd49);
        expect_out("p3", 64'd49);
        chk("p3 done busy", unit_busy, 0);

        // Reset while SEND_A is on the wire.
        send_flit(1'b0, 64'd2);
        send_flit(1'b1, 64'd3);
        begin
            int w = 0;
            while (mul_in_flit == '0 && w < 50) begin
                tick();
                w++;
            end
        end
        chk("mid slice A", mul_in_flit, {opf(1'b0, 64'd2), 71'd0});
        rst_n = 1'b0;
        tick();
        chk("mid rst slices", mul_in_flit, 0);
        chk("mid rst busy", unit_busy, 0);
        chk("mid rst in_ready", in_ready, 0);
        rst_n = 1'b1;
        tick();
        send_flit(1'b0, 64'd4);
        send_flit(1'b1, 64'd5);
        check_dispatch("post rst", 0, 64'd4, 64'd5);
        repeat (2) tick();
        strobe(2'b01, 64'd20, 64'd20);
        expect_out("post rst", 64'd20);

        // Unit that never answers.
        send_flit(1'b0, 64'd1);
        send_flit(1'b1, 64'd1);
        check_dispatch("silent", 1, 64'd1, 64'd1);
        busy_n = 0;
        pulses = 0;
        sends  = 0;
        for (int c = 0; c < 80; c++) begin
            if (unit_busy[1]) busy_n++;
            if (timeout_err) pulses++;
            if (out_send) sends++;
            tick();
        end
`ifdef MUL_SCHED_TIMEOUT_EN
        chk("timeout busy cycles", busy_n, 64);
        chk("timeout pulses", pulses, 1);
`else
        chk("no timeout busy cycles", busy_n, 80);
        chk("no timeout pulses", pulses, 0);
`endif
        chk("silent no send", sends, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
